// File: rtl/exe_busy_ctrl_pkg.sv
// Purpose : shared types and default latencies for the execute busy/writeback scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: ExeUnit_t (unit encoding), ExeBusy_t (per-unit busy vector), default unit latencies.
package exe_busy_ctrl_pkg;

  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_FPU_LAT  = 3;
  localparam int DEF_MEM_LAT  = 2;
  localparam int DEF_DIV_LAT  = 8;
  localparam int DEF_FDIV_LAT = 12;
  localparam int DEF_CSR_LAT  = 1;
  localparam int DEF_MAX_LAT  = 16;

  // Code 0 doubles as the "no unit" tag so a cleared tag slot reads as UNIT_NONE.
  // Code 7 is left unassigned and is rejected on issue.
  typedef enum logic [2:0] {
    UNIT_NONE = 3'd0,
    UNIT_ALU  = 3'd1,
    UNIT_DIV  = 3'd2,
    UNIT_FPU  = 3'd3,
    UNIT_FDIV = 3'd4,
    UNIT_CSR  = 3'd5,
    UNIT_MEM  = 3'd6
  } ExeUnit_t;

  typedef struct packed {
    logic alu;
    logic div;
    logic fpu;
    logic fdiv;
    logic csr;
    logic mem;
  } ExeBusy_t;

endpackage

// File: rtl/exe_busy_ctrl_wb_resv.sv
// Purpose : writeback reservation shift register with a parallel unit-tag array.
// Latency : a reservation set at index L-1 reaches slot 0 L-1 edges later.
// Backpressure: none; the caller guarantees the target slot is free before setting it.
// Ports   : i_clk/i_reset (async high), i_flush_n clears everything, i_set/i_set_idx/i_set_unit
//           load one slot, o_resv is the full reservation vector, o_tag0 the owner of slot 0.
module wb_resv
  import exe_busy_ctrl_pkg::*;
#(
  parameter int MAX_LAT = DEF_MAX_LAT,
  localparam int IDX_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush_n,
  input  logic               i_set,
  input  logic [IDX_W-1:0]   i_set_idx,
  input  ExeUnit_t           i_set_unit,
  output logic [MAX_LAT-1:0] o_resv,
  output ExeUnit_t           o_tag0
);

  logic [MAX_LAT-1:0] r_resv;
  logic [MAX_LAT-1:0] w_resv_nxt;
  ExeUnit_t           r_tag     [MAX_LAT];
  ExeUnit_t           w_tag_nxt [MAX_LAT];

  always_comb begin
    w_resv_nxt = r_resv >> 1;
    for (int i = 0; i < MAX_LAT - 1; i++) begin
      w_tag_nxt[i] = r_tag[i+1];
    end
    w_tag_nxt[MAX_LAT-1] = UNIT_NONE;
    // The new reservation is merged after the shift so it lands exactly L-1 slots from the head.
    if (i_set) begin
      w_resv_nxt[i_set_idx] = 1'b1;
      w_tag_nxt[i_set_idx]  = i_set_unit;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_resv <= '0;
      for (int i = 0; i < MAX_LAT; i++) r_tag[i] <= UNIT_NONE;
    end else if (!i_flush_n) begin
      r_resv <= '0;
      for (int i = 0; i < MAX_LAT; i++) r_tag[i] <= UNIT_NONE;
    end else begin
      r_resv <= w_resv_nxt;
      for (int i = 0; i < MAX_LAT; i++) r_tag[i] <= w_tag_nxt[i];
    end
  end

  assign o_resv = r_resv;
  assign o_tag0 = r_tag[0];

endmodule

// File: rtl/exe_busy_ctrl.sv
// Purpose : execute-stage busy tracking and single-port writeback slot scheduling.
// Latency : issue at t with unit latency L shows the writeback slot at t+L; issue_err one cycle after a reject.
// Backpressure: exe_busy (registered state plus mem_busy_in) tells the scheduler which units may issue.
// Ports   : clk, reset (async high), flush_ (low), issue_e_ (low) + issue_unit, mem_busy_in;
//           outputs exe_busy, wb_sched_e_ (low), wb_sched_unit, issue_err.
module exe_busy_ctrl
  import exe_busy_ctrl_pkg::*;
#(
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int FPU_LAT  = DEF_FPU_LAT,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int FDIV_LAT = DEF_FDIV_LAT,
  parameter int CSR_LAT  = DEF_CSR_LAT,
  parameter int MAX_LAT  = DEF_MAX_LAT
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush_,
  input  logic     issue_e_,
  input  ExeUnit_t issue_unit,
  input  logic     mem_busy_in,
  output ExeBusy_t exe_busy,
  output logic     wb_sched_e_,
  output ExeUnit_t wb_sched_unit,
  output logic     issue_err
);

  localparam int IDX_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  logic [MAX_LAT-1:0] w_resv;
  logic [MAX_LAT:0]   w_resv_ext;
  ExeUnit_t           w_tag0;
  logic [CNT_W-1:0]   r_div_cnt;
  logic [CNT_W-1:0]   r_fdiv_cnt;
  logic [CNT_W-1:0]   r_csr_cnt;
  logic               r_issue_err;
  logic               w_issue_req;
  logic               w_unit_ok;
  logic               w_unit_busy;
  logic               w_accept;
  logic [IDX_W-1:0]   w_set_idx;

  // A zero above the top slot makes resv[L] always indexable; L=MAX_LAT then never conflicts.
  assign w_resv_ext = {1'b0, w_resv};

  // Busy depends only on registered state and mem_busy_in, never on the issue request itself.
  always_comb begin
    exe_busy      = '0;
    exe_busy.alu  = w_resv_ext[ALU_LAT];
    exe_busy.fpu  = w_resv_ext[FPU_LAT];
    exe_busy.mem  = w_resv_ext[MEM_LAT] | mem_busy_in;
    exe_busy.div  = w_resv_ext[DIV_LAT] | (r_div_cnt != '0);
    exe_busy.fdiv = w_resv_ext[FDIV_LAT] | (r_fdiv_cnt != '0);
    exe_busy.csr  = w_resv_ext[CSR_LAT] | (r_csr_cnt != '0);
  end

  always_comb begin
    w_unit_ok   = 1'b1;
    w_unit_busy = 1'b0;
    w_set_idx   = '0;
    case (issue_unit)
      UNIT_ALU:  begin w_unit_busy = exe_busy.alu;  w_set_idx = IDX_W'(ALU_LAT - 1);  end
      UNIT_FPU:  begin w_unit_busy = exe_busy.fpu;  w_set_idx = IDX_W'(FPU_LAT - 1);  end
      UNIT_MEM:  begin w_unit_busy = exe_busy.mem;  w_set_idx = IDX_W'(MEM_LAT - 1);  end
      UNIT_DIV:  begin w_unit_busy = exe_busy.div;  w_set_idx = IDX_W'(DIV_LAT - 1);  end
      UNIT_FDIV: begin w_unit_busy = exe_busy.fdiv; w_set_idx = IDX_W'(FDIV_LAT - 1); end
      UNIT_CSR:  begin w_unit_busy = exe_busy.csr;  w_set_idx = IDX_W'(CSR_LAT - 1);  end
      default:   w_unit_ok = 1'b0;
    endcase
  end

  // A flush masks the request entirely, so a same-cycle issue is neither accepted nor flagged.
  assign w_issue_req = !issue_e_ && flush_;
  assign w_accept    = w_issue_req && w_unit_ok && !w_unit_busy;

  wb_resv #(.MAX_LAT(MAX_LAT)) u_wb_resv (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_flush_n  (flush_),
    .i_set      (w_accept),
    .i_set_idx  (w_set_idx),
    .i_set_unit (issue_unit),
    .o_resv     (w_resv),
    .o_tag0     (w_tag0)
  );

  // Iterative-unit occupancy: load L-1 on issue, count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_fdiv_cnt  <= '0;
      r_csr_cnt   <= '0;
      r_issue_err <= 1'b0;
    end else begin
      r_issue_err <= w_issue_req && !w_accept;
      if (!flush_) begin
        r_div_cnt  <= '0;
        r_fdiv_cnt <= '0;
        r_csr_cnt  <= '0;
      end else begin
        if (w_accept && issue_unit == UNIT_DIV) r_div_cnt <= CNT_W'(DIV_LAT - 1);
        else if (r_div_cnt != '0)               r_div_cnt <= r_div_cnt - 1'b1;

        if (w_accept && issue_unit == UNIT_FDIV) r_fdiv_cnt <= CNT_W'(FDIV_LAT - 1);
        else if (r_fdiv_cnt != '0)               r_fdiv_cnt <= r_fdiv_cnt - 1'b1;

        if (w_accept && issue_unit == UNIT_CSR) r_csr_cnt <= CNT_W'(CSR_LAT - 1);
        else if (r_csr_cnt != '0)               r_csr_cnt <= r_csr_cnt - 1'b1;
      end
    end
  end

  assign wb_sched_e_   = !w_resv[0];
  assign wb_sched_unit = w_tag0;
  assign issue_err     = r_issue_err;

endmodule
